// File: rtl/fx_to_fp_convert_pkg.sv
// IEEE-754 single-precision field constants shared by the fixed-to-float converter.
package fx_to_fp_convert_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 23;
   localparam int FP_W     = 1 + EXP_W + MANT_W;

   localparam logic [FP_W-1:0] FP_ZERO = 32'h0;

   function automatic logic [FP_W-1:0] pack_fp(input logic            sign,
                                                input logic [EXP_W-1:0]  exp_f,
                                                input logic [MANT_W-1:0] mant);
      return {sign, exp_f, mant};
   endfunction

endpackage

// File: rtl/fx_to_fp_convert_lzd.sv
// Leading-one detector: bit index of the most significant set bit, plus an all-zero flag.
module lzd #(
   parameter  int W  = 22,
   localparam int PW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  value,
   output logic [PW-1:0] pos,
   output logic          zero
);

   always_comb begin
      pos = '0;
      for (int i = 0; i < W; i++) begin
         if (value[i]) pos = PW'(i);
      end
   end

   assign zero = ~|value;

endmodule

// File: rtl/fx_to_fp_convert.sv
// Three-stage pipeline converting a signed fixed-point value into IEEE-754 single precision.
module fx_to_fp_convert
   import fx_to_fp_convert_pkg::*;
#(
   parameter int W         = 22,
   parameter int FRAC_BITS = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clk_en,
   input  logic         start,
   input  logic [W-1:0] dataa,
   output logic [31:0]  result,
   output logic         done
);

   localparam int PW = (W > 1) ? $clog2(W) : 1;
   localparam int NW = W - 1;

   logic          s1_valid, s1_sign;
   logic [W-1:0]  s1_mag;

   logic          s2_valid, s2_sign, s2_zero;
   logic [W-1:0]  s2_mag;
   logic [PW-1:0] s2_pos;

   logic [PW-1:0] lzd_pos;
   logic          lzd_zero;

   logic [PW-1:0]     shamt;
   logic [NW-1:0]     norm;
   logic [EXP_W-1:0]  exp_f;
   logic [MANT_W-1:0] mant;
   logic [FP_W-1:0]   fp_next;

   logic [FP_W-1:0] result_q;
   logic            done_q;

   // Negating the most negative input yields 2^(W-1), which still fits as unsigned.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mag   <= '0;
      end else if (clk_en) begin
         s1_valid <= start;
         s1_sign  <= dataa[W-1];
         s1_mag   <= dataa[W-1] ? (~dataa + 1'b1) : dataa;
      end
   end

   lzd #(.W(W)) u_lzd (
      .value (s1_mag),
      .pos   (lzd_pos),
      .zero  (lzd_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_zero  <= 1'b1;
         s2_mag   <= '0;
         s2_pos   <= '0;
      end else if (clk_en) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_zero  <= lzd_zero;
         s2_mag   <= s1_mag;
         s2_pos   <= lzd_pos;
      end
   end

   // Shift the leading one out past the top, leaving the fraction bits left-aligned.
   always_comb begin
      shamt   = PW'(W - 1) - s2_pos;
      norm    = NW'(s2_mag << shamt);
      mant    = MANT_W'({norm, {MANT_W{1'b0}}} >> NW);
      exp_f   = EXP_W'(s2_pos) + EXP_W'(EXP_BIAS - FRAC_BITS);
      fp_next = s2_zero ? FP_ZERO : pack_fp(s2_sign, exp_f, mant);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q   <= 1'b0;
         result_q <= FP_ZERO;
      end else if (clk_en) begin
         done_q <= s2_valid;
         if (s2_valid) result_q <= fp_next;
      end
   end

   assign result = result_q;
   assign done   = done_q;

endmodule
